mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the 32-bit processor datapath.
- Sequences the enables of the datapath's 32-bit enable-registers (PC, IR, RegA, RegB, ALUOut, MDR) and drives the register-file write, the datapath mux selects and the memory request handshake.
- Sits between the IR output and the datapath; it holds no data itself, only state, a timeout counter and control.

Parameters:
- TIMEOUT, 15, max consecutive unacknowledged MemReq cycles before abort; 0 disables the timeout.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Instr  in  32  IR contents; opcode = Instr[31:26], R-func = Instr[3:0]
- Zero  in  1  ALU zero flag
- MemAck  in  1  memory completes the current request this cycle
- MemReq  out  1  memory request, held until ack or abort
- MemWe  out  1  1 = write (valid only with MemReq)
- PC_En, IR_En, RegA_En, RegB_En, ALUOut_En, MDR_En  out  1 each  register load enables
- RF_WrEn  out  1  register-file write
- RF_WrSel  out  1  0 = ALUOut, 1 = MDR
- ALUSrcA  out  1  0 = PC, 1 = RegA
- ALUSrcB  out  2  00 = RegB, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- ALU_Op  out  4  0000 = add, 0001 = sub, otherwise pass Instr[3:0]
- PC_Sel  out  1  0 = ALU result, 1 = ALUOut
- IllegalOp  out  1  one-cycle pulse on an undefined opcode
- MemFault  out  1  one-cycle pulse on a memory timeout
- State  out  4  current state code (debug)

Behaviour:
- Opcodes: 100000 = R, 110000 = ADDI, 000011 = LW, 000111 = SW, 010000 = BEQ, 111111 = B.
- Reset low: state = FETCH (0), counter = 0. All outputs are forced to 0 while Reset is low, including MemReq.
- After reset release: MemReq = 1 in the first cycle.
- Default values of all outputs not listed for a state are 0.
- FETCH (0): MemReq = 1.
  - On MemAck: IR_En = 1 and PC_En = 1, with ALUSrcA = 0, ALUSrcB = 01, ALU_Op = add, PC_Sel = 0 → DECODE.
- DECODE (1): RegA_En = RegB_En = ALUOut_En = 1, with ALUSrcA = 0, ALUSrcB = 11, add (branch target).
  - R → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR; BEQ/B → BRANCH.
  - Any other opcode → FETCH, pulsing IllegalOp; PC is already advanced.
- EXEC_R (2): ALUSrcA = 1, ALUSrcB = 00, ALU_Op = Instr[3:0], ALUOut_En = 1 → WB_ALU.
- EXEC_I (3): ALUSrcA = 1, ALUSrcB = 10, add, ALUOut_En = 1 → WB_ALU.
- WB_ALU (4): RF_WrEn = 1, RF_WrSel = 0 → FETCH.
- MEM_ADDR (5): ALUSrcA = 1, ALUSrcB = 10, add, ALUOut_En = 1 → MEM_RD for LW, MEM_WR for SW.
- MEM_RD (6): MemReq = 1, MemWe = 0. On MemAck: MDR_En = 1 → WB_MEM.
- WB_MEM (7): RF_WrEn = 1, RF_WrSel = 1 → FETCH.
- MEM_WR (8): MemReq = 1, MemWe = 1. On MemAck → FETCH.
- BRANCH (9): ALUSrcA = 1, ALUSrcB = 00, sub.
  - PC_En = 1 with PC_Sel = 1 when (B) or (BEQ and Zero) → FETCH.
- Enables qualified by MemAck are Mealy outputs, asserted only in the ack cycle. All other outputs are Moore, decoded from the state.
- Each instruction is a sequence of single-cycle states except for memory waits.
  - Cycles per instruction with zero-wait memory: R/ADDI = 4, LW = 5, SW = 4, BEQ/B = 3.
- Timeout counter:
  - Cleared on entry to any memory state and on ack.
  - Increments on each MemReq cycle without MemAck.
  - When count = TIMEOUT and MemAck = 0: MemReq drops next cycle, MemFault pulses for 1 cycle, → FETCH.
  - A FETCH abort retries the same PC; no register enables fire in an aborted cycle.
- MemAck in the same cycle as the timeout threshold: the ack wins.
- MemAck in non-memory states is ignored.
- Reset asserted mid-instruction: immediate return to FETCH with outputs forced 0. No partial writes complete after the reset edge.
- Illegal State encodings (10–15) → FETCH on the next clock.

Test Plan:
- Reset low for 3 cycles, then high; MemAck = 1 from cycle 2 → all outputs 0 during reset; MemReq = 1 in the first cycle after release; IR_En = PC_En = 1 in the ack cycle; State = 1 next.
- R-type, Instr = 0x80000001 (sub), zero-wait memory → State sequence 0,1,2,4,0; ALU_Op = 0001 in state 2; RF_WrEn = 1, RF_WrSel = 0 in state 4.
- LW with MemAck delayed 3 cycles in MEM_RD → MemReq held 4 cycles; MDR_En = 1 only in the ack cycle; RF_WrSel = 1 in WB_MEM.
- BEQ with Zero = 1, then BEQ with Zero = 0, then B with Zero = 0 → PC_En = 1/0/1 respectively in BRANCH; PC_Sel = 1 when PC_En = 1.
- SW with MemAck never asserted, TIMEOUT = 15 → MemReq high for 16 cycles; MemFault single pulse; State returns to 0; no enables fire.
- Opcode 0x3E in DECODE → IllegalOp single pulse; next State = 0. Separately, Reset pulsed low during MEM_WR → MemReq drops asynchronously and State = 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller and the datapath/memory side.
interface mc_ctrl_fsm_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemAck;
    logic        MemReq;
    logic        MemWe;
    logic        PC_En;
    logic        IR_En;
    logic        RegA_En;
    logic        RegB_En;
    logic        ALUOut_En;
    logic        MDR_En;
    logic        RF_WrEn;
    logic        RF_WrSel;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALU_Op;
    logic        PC_Sel;
    logic        IllegalOp;
    logic        MemFault;
    logic [3:0]  State;

    modport master (
        input  Instr, Zero, MemAck,
        output MemReq, MemWe, PC_En, IR_En, RegA_En, RegB_En, ALUOut_En, MDR_En,
               RF_WrEn, RF_WrSel, ALUSrcA, ALUSrcB, ALU_Op, PC_Sel, IllegalOp,
               MemFault, State
    );

    modport slave (
        output Instr, Zero, MemAck,
        input  MemReq, MemWe, PC_En, IR_En, RegA_En, RegB_En, ALUOut_En, MDR_En,
               RF_WrEn, RF_WrSel, ALUSrcA, ALUSrcB, ALU_Op, PC_Sel, IllegalOp,
               MemFault, State
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences datapath enables, mux selects and the
// memory request handshake, with a timeout abort on unacknowledged requests.
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mc_ctrl_fsm_if.master m_bus
);
    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_B    = 6'b111111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_abort, w_abort_next;

    logic       w_mem_req, w_mem_we, w_pc_en, w_ir_en, w_rega_en, w_regb_en;
    logic       w_aluout_en, w_mdr_en, w_rf_wr_en, w_rf_wr_sel, w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_op;
    logic       w_pc_sel, w_illegal;
    logic [5:0] w_opcode;
    logic       w_tmo;
    logic       w_unused_bits;

    assign w_opcode      = m_bus.Instr[31:26];
    assign w_unused_bits = ^m_bus.Instr[25:4];
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT)) && !m_bus.MemAck;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_abort <= w_abort_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_abort_next = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_pc_en      = 1'b0;
        w_ir_en      = 1'b0;
        w_rega_en    = 1'b0;
        w_regb_en    = 1'b0;
        w_aluout_en  = 1'b0;
        w_mdr_en     = 1'b0;
        w_rf_wr_en   = 1'b0;
        w_rf_wr_sel  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 4'b0000;
        w_pc_sel     = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // r_abort marks the dead cycle after a timeout: no request, ack ignored
                if (!r_abort) begin
                    w_mem_req   = 1'b1;
                    w_alu_src_b = 2'b01;
                    if (m_bus.MemAck) begin
                        w_ir_en      = 1'b1;
                        w_pc_en      = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_tmo) begin
                        w_abort_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                w_rega_en   = 1'b1;
                w_regb_en   = 1'b1;
                w_aluout_en = 1'b1;
                w_alu_src_b = 2'b11;
                case (w_opcode)
                    OP_R:          w_state_next = S_EXEC_R;
                    OP_ADDI:       w_state_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_state_next = S_MEM_ADDR;
                    OP_BEQ, OP_B:  w_state_next = S_BRANCH;
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = m_bus.Instr[3:0];
                w_aluout_en  = 1'b1;
                w_state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_aluout_en  = 1'b1;
                w_state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_rf_wr_en   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_aluout_en  = 1'b1;
                w_state_next = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                if (m_bus.MemAck) begin
                    w_mdr_en     = 1'b1;
                    w_state_next = S_WB_MEM;
                end else if (w_tmo) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WB_MEM: begin
                w_rf_wr_en   = 1'b1;
                w_rf_wr_sel  = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (m_bus.MemAck) begin
                    w_state_next = S_FETCH;
                end else if (w_tmo) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 4'b0001;
                if ((w_opcode == OP_B) || ((w_opcode == OP_BEQ) && m_bus.Zero)) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 1'b1;
                end
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Every output is gated by reset so nothing can fire while it is held low
    assign m_bus.MemReq    = i_rst_n & w_mem_req;
    assign m_bus.MemWe     = i_rst_n & w_mem_we;
    assign m_bus.PC_En     = i_rst_n & w_pc_en;
    assign m_bus.IR_En     = i_rst_n & w_ir_en;
    assign m_bus.RegA_En   = i_rst_n & w_rega_en;
    assign m_bus.RegB_En   = i_rst_n & w_regb_en;
    assign m_bus.ALUOut_En = i_rst_n & w_aluout_en;
    assign m_bus.MDR_En    = i_rst_n & w_mdr_en;
    assign m_bus.RF_WrEn   = i_rst_n & w_rf_wr_en;
    assign m_bus.RF_WrSel  = i_rst_n & w_rf_wr_sel;
    assign m_bus.ALUSrcA   = i_rst_n & w_alu_src_a;
    assign m_bus.ALUSrcB   = i_rst_n ? w_alu_src_b : 2'b00;
    assign m_bus.ALU_Op    = i_rst_n ? w_alu_op : 4'b0000;
    assign m_bus.PC_Sel    = i_rst_n & w_pc_sel;
    assign m_bus.IllegalOp = i_rst_n & w_illegal;
    assign m_bus.MemFault  = i_rst_n & r_abort;
    assign m_bus.State     = i_rst_n ? 4'(r_state) : 4'd0;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: per-instruction cycle traces are derived from the
// instruction semantics, pushed as expectations, and compared by a monitor.
module tb_mc_ctrl_fsm;
    localparam int TMO = 15;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_B    = 6'b111111;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_B = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .m_bus   (bus)
    );

    typedef struct packed {
        logic       req, we, pc_en, ir_en, ra_en, rb_en, ao_en, mdr_en, rf_we, rf_sel, srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic       pc_sel, ill, fault;
        logic [3:0] st;
    } obs_t;

    typedef struct packed {
        logic ack;
        logic zero;
        obs_t exp;
    } item_t;

    item_t plan[$];
    obs_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    release_pending = 1'b0;
    logic [31:0] cur_instr = '0;

    always @(posedge clk) cyc++;

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic ack, input logic zero, input obs_t o);
        item_t it;
        it.ack = ack;
        it.zero = zero;
        it.exp = o;
        plan.push_back(it);
    endtask

    // Memory-wait segment: wait_n idle cycles then ack, or a full timeout + dead cycle
    task automatic mem_seg(input logic [3:0] st, input int wait_n, input bit tmo);
        obs_t o;
        obs_t ab;
        o = blank(st);
        o.req = 1'b1;
        o.we = (st == 4'd8);
        if (st == 4'd0) o.srcb = 2'b01;
        if (tmo) begin
            for (int i = 0; i <= TMO; i++) add(1'b0, rbit(), o);
            ab = blank(4'd0);
            ab.fault = 1'b1;
            add(rbit(), rbit(), ab);
        end else begin
            for (int i = 0; i < wait_n; i++) add(1'b0, rbit(), o);
            if (st == 4'd0) begin
                o.ir_en = 1'b1;
                o.pc_en = 1'b1;
            end
            if (st == 4'd6) o.mdr_en = 1'b1;
            add(1'b1, rbit(), o);
        end
    endtask

    task automatic add_decode(input bit ill);
        obs_t o;
        o = blank(4'd1);
        o.ra_en = 1'b1;
        o.rb_en = 1'b1;
        o.ao_en = 1'b1;
        o.srcb = 2'b11;
        o.ill = ill;
        add(rbit(), rbit(), o);
    endtask

    task automatic add_addr_calc(input logic [3:0] st);
        obs_t o;
        o = blank(st);
        o.srca = 1'b1;
        o.srcb = 2'b10;
        o.ao_en = 1'b1;
        add(rbit(), rbit(), o);
    endtask

    task automatic build(input int kind, input logic zero_br, input int fw, input bit ft,
                         input int mw, input bit mt, input logic [3:0] func);
        obs_t o;
        mem_seg(4'd0, fw, ft);
        if (ft) mem_seg(4'd0, fw, 1'b0);
        add_decode(kind == K_ILL);
        case (kind)
            K_R: begin
                o = blank(4'd2);
                o.srca = 1'b1;
                o.aluop = func;
                o.ao_en = 1'b1;
                add(rbit(), rbit(), o);
                o = blank(4'd4);
                o.rf_we = 1'b1;
                add(rbit(), rbit(), o);
            end
            K_ADDI: begin
                add_addr_calc(4'd3);
                o = blank(4'd4);
                o.rf_we = 1'b1;
                add(rbit(), rbit(), o);
            end
            K_LW: begin
                add_addr_calc(4'd5);
                mem_seg(4'd6, mw, mt);
                if (!mt) begin
                    o = blank(4'd7);
                    o.rf_we = 1'b1;
                    o.rf_sel = 1'b1;
                    add(rbit(), rbit(), o);
                end
            end
            K_SW: begin
                add_addr_calc(4'd5);
                mem_seg(4'd8, mw, mt);
            end
            K_BEQ, K_B: begin
                o = blank(4'd9);
                o.srca = 1'b1;
                o.aluop = 4'b0001;
                if (kind == K_B || zero_br) begin
                    o.pc_en = 1'b1;
                    o.pc_sel = 1'b1;
                end
                add(rbit(), zero_br, o);
            end
            default: ;
        endcase
    endtask

    task automatic run_plan();
        item_t it;
        while (plan.size() > 0) begin
            it = plan.pop_front();
            @(posedge clk);
            #1;
            if (release_pending) begin
                rst_n = 1'b1;
                release_pending = 1'b0;
            end
            bus.Instr  = cur_instr;
            bus.Zero   = it.zero;
            bus.MemAck = it.ack;
            sb.push_back(it.exp);
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input int kind, input logic zero_br,
                            input int fw, input bit ft, input int mw, input bit mt,
                            input logic [3:0] func);
        int n;
        cur_instr = {op, 22'($urandom), func};
        build(kind, zero_br, fw, ft, mw, mt, func);
        n = plan.size();
        run_plan();
        $display("instr %08h kind=%0d fwait=%0d ftmo=%0d mwait=%0d mtmo=%0d cycles=%0d",
                 cur_instr, kind, fw, ft, mw, mt, n);
    endtask

    task automatic reset_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            bus.MemAck = 1'b0;
            sb.push_back('0);
        end
        release_pending = 1'b1;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.MemReq, bus.MemWe, bus.PC_En, bus.IR_En, bus.RegA_En, bus.RegB_En,
                 bus.ALUOut_En, bus.MDR_En, bus.RF_WrEn, bus.RF_WrSel, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALU_Op, bus.PC_Sel, bus.IllegalOp, bus.MemFault, bus.State};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d exp_state=%0d got=%h exp=%h", cyc, e.st, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        logic [5:0] op;
        int fw, mw;
        bit ft, mt;
        bus.Instr  = '0;
        bus.Zero   = 1'b0;
        bus.MemAck = 1'b0;
        rst_n      = 1'b0;

        // Reset for 3 cycles, MemAck already high before release
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            bus.MemAck = (c >= 1);
            sb.push_back('0);
        end
        release_pending = 1'b1;

        do_instr(OP_R,   K_R,   1'b0, 0, 1'b0, 0, 1'b0, 4'b0001);
        do_instr(OP_LW,  K_LW,  1'b0, 0, 1'b0, 3, 1'b0, 4'h0);
        do_instr(OP_BEQ, K_BEQ, 1'b1, 0, 1'b0, 0, 1'b0, 4'h0);
        do_instr(OP_BEQ, K_BEQ, 1'b0, 0, 1'b0, 0, 1'b0, 4'h0);
        do_instr(OP_B,   K_B,   1'b0, 0, 1'b0, 0, 1'b0, 4'h0);
        do_instr(OP_SW,  K_SW,  1'b0, 0, 1'b0, 0, 1'b1, 4'h0);
        do_instr(6'h3E,  K_ILL, 1'b0, 0, 1'b0, 0, 1'b0, 4'h0);
        do_instr(OP_ADDI, K_ADDI, 1'b0, TMO, 1'b0, 0, 1'b0, 4'h0);
        do_instr(OP_R,   K_R,   1'b0, 1, 1'b1, 0, 1'b0, 4'h7);

        // Reset pulsed in the middle of MEM_WR
        cur_instr = {OP_SW, 26'h0};
        mem_seg(4'd0, 0, 1'b0);
        add_decode(1'b0);
        add_addr_calc(4'd5);
        run_plan();
        @(posedge clk);
        #1;
        bus.MemAck = 1'b0;
        rst_n = 1'b0;
        sb.push_back('0);
        $display("reset pulsed during MEM_WR");
        reset_cycles(2);

        repeat (60) begin
            kind = $urandom_range(0, 6);
            case (kind)
                K_R:    op = OP_R;
                K_ADDI: op = OP_ADDI;
                K_LW:   op = OP_LW;
                K_SW:   op = OP_SW;
                K_BEQ:  op = OP_BEQ;
                K_B:    op = OP_B;
                default: begin
                    op = 6'($urandom);
                    while (op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW ||
                           op == OP_BEQ || op == OP_B)
                        op = 6'($urandom);
                end
            endcase
            fw = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            ft = ($urandom_range(0, 9) == 0);
            mt = ($urandom_range(0, 5) == 0);
            do_instr(op, kind, rbit(), fw, ft, mw, mt, 4'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
